// File: rtl/delay_dn.sv
// delay_dn: multi-channel token delay actor, DELAY tokens per channel,
// round-robin arbitration, one token per cycle across all channels.
module delay_dn #(
  parameter int FLUX = 2,
  parameter int DELAY = 1,
  parameter int DATA_WIDTH = 18,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [FLUX-1:0]               in_empty,
  input  logic [DATA_WIDTH+TAG_WIDTH-1:0] in_dout,
  output logic [FLUX-1:0]               in_read,
  input  logic [FLUX-1:0]               out_full,
  output logic [TAG_WIDTH+DATA_WIDTH-1:0] out_din,
  output logic                          out_write,
  input  logic [FLUX-1:0]               flush
);

  localparam int PW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int FW = $clog2(DELAY + 1);
  localparam int DEPTH = FLUX * DELAY;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         ptr [FLUX];
  logic [FW-1:0]         fill [FLUX];
  logic [TAG_WIDTH-1:0]  rr_ptr;
  logic [TAG_WIDTH-1:0]  gnt;
  logic                  found;
  logic                  fire;
  logic [FLUX-1:0]       elig;
  logic [PW-1:0]         gnt_ptr;
  logic [FW-1:0]         gnt_fill;
  logic [AW-1:0]         addr;
  logic [DATA_WIDTH-1:0] q;
  logic [DATA_WIDTH-1:0] din;
  logic                  unused_tag;

  assign elig = ~in_empty & ~out_full;
  assign din = in_dout[DATA_WIDTH-1:0];
  assign unused_tag = ^in_dout[DATA_WIDTH +: TAG_WIDTH];

  // Two passes: channels at or above rr_ptr first, then the wrapped ones.
  always_comb begin
    found = 1'b0;
    gnt = '0;
    for (int c = 0; c < FLUX; c++) begin
      if (!found && elig[c] && TAG_WIDTH'(c) >= rr_ptr) begin
        found = 1'b1;
        gnt = TAG_WIDTH'(c);
      end
    end
    for (int c = 0; c < FLUX; c++) begin
      if (!found && elig[c]) begin
        found = 1'b1;
        gnt = TAG_WIDTH'(c);
      end
    end
  end

  assign fire = found & ~rst;

  always_comb begin
    gnt_ptr = '0;
    gnt_fill = '0;
    for (int c = 0; c < FLUX; c++) begin
      if (gnt == TAG_WIDTH'(c)) begin
        gnt_ptr = ptr[c];
        gnt_fill = fill[c];
      end
    end
  end

  assign addr = AW'(gnt) * AW'(DELAY) + AW'(gnt_ptr);
  // Fill counter masks stale memory left over from before reset/flush.
  assign q = (gnt_fill < FW'(DELAY)) ? INIT_VALUE : mem[addr];

  always_comb begin
    in_read = '0;
    for (int c = 0; c < FLUX; c++) begin
      in_read[c] = fire && (gnt == TAG_WIDTH'(c));
    end
  end

  assign out_write = fire;
  assign out_din = {gnt, q};

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      for (int c = 0; c < FLUX; c++) begin
        ptr[c] <= '0;
        fill[c] <= '0;
      end
    end else begin
      if (fire) begin
        rr_ptr <= (gnt == TAG_WIDTH'(FLUX - 1)) ? '0
                : gnt + TAG_WIDTH'(1);
      end
      for (int c = 0; c < FLUX; c++) begin
        if (fire && gnt == TAG_WIDTH'(c)) begin
          ptr[c] <= (ptr[c] == PW'(DELAY - 1)) ? '0
                  : ptr[c] + PW'(1);
          if (fill[c] != FW'(DELAY)) begin
            fill[c] <= fill[c] + FW'(1);
          end
        end
        // Flush overrides a same-cycle fire on this channel.
        if (flush[c]) begin
          ptr[c] <= '0;
          fill[c] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fire) begin
      mem[addr] <= din;
    end
  end

endmodule

// File: tb/tb_delay_dn.sv
// tb_delay_dn: directed and random stimulus for delay_dn, checked against
// a per-channel token-history model with round-robin grant prediction.
module tb_delay_dn;

  localparam int F = 3;
  localparam int D = 3;
  localparam int W = 18;
  localparam int TW = 2;
  localparam logic [W-1:0] INIT = 18'h2A5A5;

  logic            clk = 1'b0;
  logic            rst;
  logic [F-1:0]    in_empty;
  logic [W+TW-1:0] in_dout;
  logic [F-1:0]    in_read;
  logic [F-1:0]    out_full;
  logic [TW+W-1:0] out_din;
  logic            out_write;
  logic [F-1:0]    flush;

  always #5 clk = ~clk;

  delay_dn #(
    .FLUX(F),
    .DELAY(D),
    .DATA_WIDTH(W),
    .INIT_VALUE(INIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_empty(in_empty),
    .in_dout(in_dout),
    .in_read(in_read),
    .out_full(out_full),
    .out_din(out_din),
    .out_write(out_write),
    .flush(flush)
  );

  int checks = 0;
  int failures = 0;
  logic [W-1:0] feed [F][$];
  logic [W-1:0] hist [F][$];
  int rr = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, check combinational outputs, then
  // advance the model past the rising edge.
  task automatic cyc(input logic r, input logic [F-1:0] blk,
                     input logic [F-1:0] full, input logic [F-1:0] fl);
    int g;
    int c;
    int n;
    logic [W-1:0] q;
    logic [F-1:0] emp;
    @(negedge clk);
    for (int i = 0; i < F; i++) begin
      emp[i] = blk[i] || (feed[i].size() == 0);
    end
    g = -1;
    if (!r) begin
      for (int i = 0; i < F; i++) begin
        c = (rr + i) % F;
        if (g < 0 && !emp[c] && !full[c]) g = c;
      end
    end
    rst = r;
    in_empty = emp;
    out_full = full;
    flush = fl;
    if (g >= 0) in_dout = {TW'($urandom), feed[g][0]};
    else in_dout = (W + TW)'($urandom);
    #1;
    if (g < 0) begin
      chk("in_read_idle", 32'(in_read), 32'd0);
      chk("out_write_idle", 32'(out_write), 32'd0);
    end else begin
      n = hist[g].size();
      if (n < D) q = INIT;
      else q = hist[g][n - D];
      chk("in_read", 32'(in_read), 32'(1 << g));
      chk("out_write", 32'(out_write), 32'd1);
      chk("out_din", 32'(out_din), 32'({TW'(g), q}));
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < F; i++) hist[i].delete();
      rr = 0;
    end else begin
      if (g >= 0) begin
        hist[g].push_back(feed[g].pop_front());
        rr = (g + 1) % F;
      end
      for (int i = 0; i < F; i++) begin
        if (fl[i]) hist[i].delete();
      end
    end
  endtask

  task automatic clear_feeds();
    for (int i = 0; i < F; i++) feed[i].delete();
  endtask

  initial begin
    rst = 1'b1;
    in_empty = '1;
    out_full = '0;
    flush = '0;
    in_dout = '0;

    // Reset with a channel holding data: no handshake may occur.
    feed[0].push_back(18'd9);
    cyc(1'b1, 3'b000, 3'b000, 3'b000);
    cyc(1'b1, 3'b000, 3'b000, 3'b000);
    clear_feeds();
    cyc(1'b0, 3'b000, 3'b000, 3'b000);

    // Single channel, 20 tokens, several pointer wraps.
    for (int k = 0; k < 20; k++) feed[0].push_back(W'(5 + k));
    for (int k = 0; k < 22; k++) cyc(1'b0, 3'b110, 3'b000, 3'b000);

    // All channels eligible: strict rotation 0,1,2.
    cyc(1'b1, 3'b111, 3'b000, 3'b000);
    clear_feeds();
    for (int c = 0; c < F; c++)
      for (int k = 0; k < 10; k++) feed[c].push_back(W'(c * 16 + k));
    for (int k = 0; k < 32; k++) cyc(1'b0, 3'b000, 3'b000, 3'b000);

    // Backpressure on channel 0.
    cyc(1'b1, 3'b111, 3'b000, 3'b000);
    clear_feeds();
    for (int k = 0; k < 20; k++) begin
      feed[0].push_back(W'(100 + k));
      feed[1].push_back(W'(200 + k));
    end
    for (int k = 0; k < 10; k++) cyc(1'b0, 3'b100, 3'b001, 3'b000);
    for (int k = 0; k < 30; k++) cyc(1'b0, 3'b100, 3'b000, 3'b000);

    // Flush pulsed in the cycle that input 4 fires.
    cyc(1'b1, 3'b111, 3'b000, 3'b000);
    clear_feeds();
    for (int k = 1; k <= 10; k++) feed[0].push_back(W'(k));
    for (int k = 0; k < 11; k++) begin
      if (feed[0].size() > 0 && feed[0][0] == W'(4))
        cyc(1'b0, 3'b110, 3'b000, 3'b001);
      else
        cyc(1'b0, 3'b110, 3'b000, 3'b000);
    end

    // Mid-stream reset.
    cyc(1'b1, 3'b111, 3'b000, 3'b000);
    clear_feeds();
    for (int c = 0; c < F; c++)
      for (int k = 0; k < 12; k++) feed[c].push_back(W'(c * 64 + k));
    for (int k = 0; k < 7; k++) cyc(1'b0, 3'b000, 3'b000, 3'b000);
    cyc(1'b1, 3'b000, 3'b000, 3'b000);
    for (int k = 0; k < 32; k++) cyc(1'b0, 3'b000, 3'b000, 3'b000);

    // Random traffic, flushes and occasional resets.
    for (int k = 0; k < 3000; k++) begin
      logic [F-1:0] fl;
      for (int c = 0; c < F; c++) begin
        while (feed[c].size() < 4) feed[c].push_back(W'($urandom));
      end
      fl = ($urandom % 16 == 0) ? F'($urandom) : '0;
      cyc(($urandom % 200) == 0, F'($urandom % 8 & $urandom % 8),
          F'($urandom % 8 & $urandom % 8), fl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
